// File: rtl/mult_seq_ctrl.sv
// Sequencer for a downstream shift-add multiplier: queues operand pairs, issues one
// job at a time, captures the product with a handshake and aborts jobs that never finish.
module mult_seq_ctrl #(
   parameter int N       = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 2*N+4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           mul_start,
   output logic [N-1:0]   mul_multiplicand,
   output logic [N-1:0]   mul_multiplier,
   input  logic [2*N-1:0] mul_product,
   input  logic           mul_done,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_product,
   output logic           busy,
   output logic           timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT+1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t          state, state_nx;
   logic [2*N-1:0]  fifo_mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic [2*N-1:0]  head;
   logic            empty, full, push, pop;
   logic [CW-1:0]   wait_cnt;
   logic            done_ok, expired;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pop      = (state == IDLE) && !empty;
   assign head     = fifo_mem[rd_ptr[AW-1:0]];

   // A done seen in the first WAIT cycle belongs to the previous job.
   assign done_ok  = (state == WAIT) && (wait_cnt != '0) && mul_done;
   assign expired  = (state == WAIT) && (wait_cnt == CW'(TIMEOUT-1));

   assign mul_start = (state == ISSUE);
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (!empty) state_nx = ISSUE;
         ISSUE: state_nx = WAIT;
         WAIT: begin
            if (done_ok)      state_nx = HOLD;
            else if (expired) state_nx = IDLE;
         end
         HOLD:  if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {in_a, in_b};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         mul_multiplicand <= '0;
         mul_multiplier   <= '0;
         wait_cnt         <= '0;
         out_valid        <= 1'b0;
         out_product      <= '0;
         timeout_err      <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) begin
            rd_ptr           <= rd_ptr + (AW+1)'(1);
            mul_multiplicand <= head[2*N-1:N];
            mul_multiplier   <= head[N-1:0];
         end
         if (state == ISSUE) wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
         if (done_ok) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
         end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
         end
         if (expired && !done_ok) timeout_err <= 1'b1;
      end
   end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  N, 8, operand width
  DEPTH, 4, operand FIFO depth (power of 2, >=2)
  TIMEOUT, 2*N+4, maximum WAIT cycles before abort
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); one clock, reset synchronous and active-high:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  operand pair offered
  in_ready  out  1  FIFO can accept pair
  in_a  in  N  multiplicand
  in_b  in  N  multiplier
  mul_start  out  1  start pulse to downstream shift-add multiplier
  mul_multiplicand  out  N  operand A to multiplier
  mul_multiplier  out  N  operand B to multiplier
  mul_product  in  2N  product from multiplier
  mul_done  in  1  multiplier completion flag (may stay high between jobs)
  out_valid  out  1  result held
  out_ready  in  1  consumer accepts result
  out_product  out  2N  captured product
  busy  out  1  job queued or in flight
  timeout_err  out  1  sticky abort flag

Function
REQ-003 FIFO SHALL store DEPTH {in_a,in_b} pairs; push on in_valid && in_ready; in_ready = !full (no push when full, even if pop occurs same cycle).
REQ-004 FSM SHALL have states IDLE, ISSUE, WAIT, HOLD.
REQ-005 IDLE: if FIFO non-empty, pop head, register it onto mul_multiplicand/mul_multiplier, go ISSUE; else stay.
REQ-006 ISSUE: mul_start SHALL be 1 for exactly this one cycle; clear wait counter; next state WAIT.
REQ-007 mul_multiplicand/mul_multiplier SHALL stay stable from ISSUE through the end of WAIT.
REQ-008 WAIT: mul_done SHALL be ignored in the first WAIT cycle (stale done from prior job); from the second WAIT cycle, mul_done=1 captures mul_product into out_product, sets out_valid at the next edge, goes HOLD.
REQ-009 WAIT: counter increments each cycle; when it reaches TIMEOUT without accepted done, set timeout_err, leave out_valid 0, go IDLE; the job is dropped.
REQ-010 HOLD: out_valid=1, out_product stable; on out_ready=1, clear out_valid at that edge and go IDLE.
REQ-011 mul_done outside WAIT SHALL have no effect.
REQ-012 Latency: pair pushed at edge E0 into empty FIFO with FSM in IDLE -> IDLE pops at E1, mul_start high E1..E2, WAIT from E2; out_valid rises one edge after done is accepted.
REQ-013 Jobs SHALL complete in FIFO order; one job in flight at a time.
REQ-014 busy = (state != IDLE) || FIFO non-empty.
REQ-015 timeout_err SHALL stay 1 until reset; later jobs still proceed normally.
REQ-016 Product width 2N; no truncation or sign handling (unsigned).

Reset
REQ-017 On rst=1 at a clock edge: state IDLE, FIFO empty, mul_start 0, operand outputs 0, out_valid 0, out_product 0, timeout_err 0, counter 0; in_ready 1 from the first cycle after reset.
REQ-018 Reset mid-operation (any state) SHALL discard queued and in-flight jobs; no out_valid pulse follows.

Verification
REQ-019 Single job: push 5,3; model done 2N+1 cycles after start -> mul_start single-cycle pulse, out_product=16'h000F, out_valid until out_ready.
REQ-020 Max operands: 255x255 -> out_product=16'hFE01.
REQ-021 Fill: push 5 pairs back-to-back while FSM stalled in HOLD (out_ready=0) -> in_ready=0 once FIFO holds 4 pairs after the first pop; results emerge in push order once out_ready=1.
REQ-022 Stale done: mul_done held 1 from the previous job -> not accepted in the first WAIT cycle; product captured only on a later done.
REQ-023 Timeout: mul_done tied 0 -> timeout_err=1 after 20 WAIT cycles, out_valid stays 0, next job then completes correctly.
REQ-024 Reset asserted in WAIT with 2 pairs queued -> all outputs at reset values, busy=0, no result emitted.
